shift_unit_arbiter: RTL and testbench

// Shares one combinational shift datapath (SLL/SRL/SRA, 32-bit) between NREQ

---
 rtl/shift_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/shift_units.sv | 31 +++
 rtl/shift_unit_arbiter.sv | 95 +++++++++
 tb/tb_shift_unit_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift-unit arbiter: operation encoding, response-register
// state and the requester-id width helper.
package shift_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'd0,
    SHIFT_SRL  = 2'd1,
    SHIFT_SRA  = 2'd2,
    SHIFT_PASS = 2'd3
  } shift_op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_t;

  // A single requester still needs a one-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr (wrapping)
// wins; produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shift_units.sv
// Combinational 32-bit shifters shared by the arbiter datapath: logical left,
// logical right and arithmetic right.
module shift_left_logical #(
  parameter int N = 32
) (
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         y
);
  assign y = a << shamt;
endmodule

module shift_right_logical #(
  parameter int N = 32
) (
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         y
);
  assign y = a >> shamt;
endmodule

module shift_right_arithmetic #(
  parameter int N = 32
) (
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         y
);
  assign y = N'($signed(a) >>> shamt);
endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one shift datapath between NREQ requesters: round-robin accept of one
// request per cycle into a single result register with a valid/ready output.
module shift_unit_arbiter
  import shift_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int NREQ = 2,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*N-1:0]       req_in,
  input  logic [NREQ*SHAMT_W-1:0] req_shamt,
  input  logic [NREQ*2-1:0]       req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [N-1:0]            rsp_data,
  output logic [ID_W-1:0]         rsp_id
);

  // Handshake: a request transfers on a cycle where req_valid[g] & req_ready[g];
  // the result transfers on a cycle where rsp_valid & rsp_ready. req_ready is
  // only raised when the result register is empty or being drained this cycle.

  rsp_state_t        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   next_ptr;
  logic              can_accept;
  logic              accept;
  logic [N-1:0]      sel_in;
  logic [SHAMT_W-1:0] sel_shamt;
  shift_op_t         sel_op;
  logic [N-1:0]      sll_y, srl_y, sra_y, result;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign rsp_valid  = (state == ST_FULL);
  assign can_accept = rst_n & (~rsp_valid | rsp_ready);
  assign req_ready  = can_accept ? grant : '0;
  assign accept     = |req_ready;
  assign next_ptr   = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Only the winner's fields are selected, so other requesters' inputs never
  // reach the result register.
  always_comb begin
    sel_in    = req_in[int'(grant_idx)*N +: N];
    sel_shamt = req_shamt[int'(grant_idx)*SHAMT_W +: SHAMT_W];
    sel_op    = shift_op_t'(req_op[int'(grant_idx)*2 +: 2]);
  end

  shift_left_logical     #(.N(N)) u_sll (.a(sel_in), .shamt(sel_shamt), .y(sll_y));
  shift_right_logical    #(.N(N)) u_srl (.a(sel_in), .shamt(sel_shamt), .y(srl_y));
  shift_right_arithmetic #(.N(N)) u_sra (.a(sel_in), .shamt(sel_shamt), .y(sra_y));

  always_comb begin
    result = sel_in;
    case (sel_op)
      SHIFT_SLL:  result = sll_y;
      SHIFT_SRL:  result = srl_y;
      SHIFT_SRA:  result = sra_y;
      SHIFT_PASS: result = sel_in;
      default:    result = sel_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (rsp_ready && !accept) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (accept) begin
        rsp_data <= result;
        rsp_id   <= grant_idx;
        rr_ptr   <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: directed ops/fairness/backpressure/reset cases
// plus a long random run checked against a reference model and result queue.
module tb_shift_unit_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_in;
  logic [NREQ*5-1:0] req_shamt;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [ID_W-1:0]   rsp_id;

  shift_unit_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .req_shamt (req_shamt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [ID_W+N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                            input logic [1:0] op);
    case (op)
      2'd0:    return a << s;
      2'd1:    return a >> s;
      2'd2:    return 32'($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  // Reference model of the arbiter, evaluated at each falling edge.
  logic            m_full = 1'b0;
  int              m_ptr  = 0;
  logic            m_hold = 1'b0;
  logic [N-1:0]    hold_data;
  logic [ID_W-1:0] hold_id;

  always @(negedge clk) begin
    logic            ca;
    int              win;
    int              idx;
    logic [NREQ-1:0] exp_ready;
    logic [ID_W+N-1:0] e;
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 0;
      m_hold = 1'b0;
      exp_q.delete();
      check("rst_valid", 64'(rsp_valid), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
    end else begin
      check("rsp_valid", 64'(rsp_valid), 64'(m_full));
      if (m_hold) begin
        check("hold_data", 64'(rsp_data), 64'(hold_data));
        check("hold_id", 64'(rsp_id), 64'(hold_id));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("dup_result", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e[N +: ID_W]));
          check("rsp_data", 64'(rsp_data), 64'(e[N-1:0]));
        end
      end
      ca  = !m_full || rsp_ready;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
      exp_ready = (ca && win >= 0) ? NREQ'(1 << win) : '0;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      m_hold    = m_full && !rsp_ready;
      hold_data = rsp_data;
      hold_id   = rsp_id;
      if (exp_ready != '0) begin
        exp_q.push_back({ID_W'(win),
                         ref_shift(req_in[win*N +: N], req_shamt[win*5 +: 5], req_op[win*2 +: 2])});
        m_ptr = (win + 1) % NREQ;
      end
      m_full = (exp_ready != '0) || (m_full && !rsp_ready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [31:0] a, input logic [4:0] s,
                         input logic [1:0] op);
    req_in[id*N +: N]    = a;
    req_shamt[id*5 +: 5] = s;
    req_op[id*2 +: 2]    = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated request from id, checked against a literal expected value;
  // the other requester carries junk that must not leak into the result.
  task automatic do_one(input int id, input logic [31:0] a, input logic [4:0] s,
                        input logic [1:0] op, input logic [31:0] exp, input string tag);
    set_req(id, a, s, op);
    set_req(1 - id, 32'hxxxx_xxxx, 5'bx, 2'bx);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b1;
    step();
    check({tag, "_v"}, 64'(rsp_valid), 64'd1);
    check(tag, 64'(rsp_data), 64'(exp));
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
    req_valid = '0;
    set_req(1 - id, '0, '0, '0);
    step();
    check({tag, "_drain"}, 64'(rsp_valid), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [N-1:0]    bp_data;
  logic [ID_W-1:0] bp_id;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_in    = '0;
    req_shamt = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    check("reset_data", 64'(rsp_data), 64'd0);
    check("reset_id", 64'(rsp_id), 64'd0);
    rst_n = 1'b1;
    step();

    // fairness: both requesting, consumer always ready
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(0, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      set_req(1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      step();
      check("fair_valid", 64'(rsp_valid), 64'd1);
      check("fair_id", 64'(rsp_id), 64'(i % 2));
    end

    // backpressure: hold the result for three cycles
    rsp_ready = 1'b0;
    #1;
    check("bp_ready0", 64'(req_ready), 64'd0);
    bp_data = rsp_data;
    bp_id   = rsp_id;
    for (int i = 0; i < 3; i++) begin
      set_req(0, $urandom, 5'd3, 2'd0);
      set_req(1, $urandom, 5'd7, 2'd2);
      step();
      check("bp_data", 64'(rsp_data), 64'(bp_data));
      check("bp_id", 64'(rsp_id), 64'(bp_id));
      check("bp_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release", 64'(req_ready), 64'b01);
    step();
    check("bp_next_id", 64'(rsp_id), 64'd0);
    req_valid = '0;
    step();
    check("bp_drain", 64'(rsp_valid), 64'd0);

    // drain: a single request from 1, then the pointer must favour 0
    set_req(1, 32'h1234_5678, 5'd8, 2'd1);
    req_valid = 2'b10;
    step();
    check("drain_v", 64'(rsp_valid), 64'd1);
    check("drain_data", 64'(rsp_data), 64'h0012_3456);
    req_valid = '0;
    step();
    check("drain_empty", 64'(rsp_valid), 64'd0);
    req_valid = 2'b11;
    #1;
    check("ptr_adv", 64'(req_ready), 64'b01);
    step();
    req_valid = '0;
    step();

    // operation table
    do_one(0, 32'h8000_00F1, 5'd4, 2'd0, 32'h0000_0F10, "sll4");
    do_one(1, 32'h8000_00F1, 5'd4, 2'd1, 32'h0800_000F, "srl4");
    do_one(0, 32'h8000_00F1, 5'd4, 2'd2, 32'hF800_000F, "sra4");
    do_one(1, 32'h8000_00F1, 5'd4, 2'd3, 32'h8000_00F1, "pass4");
    do_one(0, 32'h8000_00F1, 5'd0, 2'd0, 32'h8000_00F1, "sll0");
    do_one(1, 32'h8000_00F1, 5'd0, 2'd1, 32'h8000_00F1, "srl0");
    do_one(0, 32'h8000_00F1, 5'd0, 2'd2, 32'h8000_00F1, "sra0");
    do_one(1, 32'h8000_00F1, 5'd31, 2'd2, 32'hFFFF_FFFF, "sra31");
    do_one(0, 32'h8000_00F1, 5'd31, 2'd1, 32'h0000_0001, "srl31");
    do_one(1, 32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, "sll31");

    // reset while FULL, pointer sitting at 1
    set_req(0, 32'hDEAD_BEEF, 5'd1, 2'd0);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    step();
    check("pre_rst_full", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_v", 64'(rsp_valid), 64'd0);
    check("async_rst_d", 64'(rsp_data), 64'd0);
    req_valid = 2'b11;
    repeat (2) step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    step();
    check("post_rst_id", 64'(rsp_id), 64'd0);
    req_valid = '0;
    step();

    // random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREQ; r++)
        set_req(r, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      step();
    end

    // flush: every pushed result must have come out exactly once
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    check("lost_results", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
